// File: rtl/multiword_add_seq.sv
// multiword_add_seq: W*K-bit add/subtract built from one W-bit CLA stepped over K words, LS word first
module multiword_add_seq #(
    parameter int W = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           op_sub,
    input  logic           cin,
    input  logic [W*K-1:0] a,
    input  logic [W*K-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*K-1:0] sum,
    output logic           cout,
    output logic           ovf
);
    localparam int N  = W * K;
    localparam int IW = K > 1 ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_r, b_r;
    logic           carry;
    logic [IW-1:0]  idx;
    logic [W-1:0]   wa, wb, g, p, ws;
    logic [W:0]     c;
    logic           gg, pp, last;

    // one W-bit carry-look-ahead step on the current word pair and registered carry
    always_comb begin
        wa = a_r[idx*W +: W];
        wb = b_r[idx*W +: W];
        g = wa & wb;
        p = wa ^ wb;
        c = '0;
        c[0] = carry;
        gg = 1'b0;
        pp = 1'b0;
        for (int i = 0; i < W; i++) begin
            gg = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & carry);
        end
        ws = p ^ c[W-1:0];
        last = idx == IW'(K - 1);
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // next state and handshake decodes
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? RUN : IDLE;
            RUN:  state_nx = last ? DONE : RUN;
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture on accept, then one result word and carry per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            carry <= 1'b0;
            idx <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            idx <= '0;
        end else if (state == RUN) begin
            sum[idx*W +: W] <= ws;
            carry <= c[W];
            idx <= idx + IW'(1);
            if (last) begin
                cout <= c[W];
                ovf <= c[W] ^ c[W-1];
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: random and directed checks of the multiword sequencer against an arithmetic model
module tb_multiword_add_seq;
    localparam int W = 4;
    localparam int K = 4;
    localparam int N = W * K;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic         cin = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int passed = 0;

    int           cyc = 0;
    int           acc = 0;
    bit           busy = 1'b0;
    bit           known = 1'b0;
    logic [N+1:0] pend = '0;
    logic [N+1:0] expv = '0;

    multiword_add_seq #(.W(W), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .cin(cin), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // {cout, ovf, sum} from plain wide and signed integer arithmetic
    function automatic logic [N+1:0] calc(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic s, input logic c);
        int           sx, sy, r;
        longint       u;
        logic [N-1:0] res;
        logic         co, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            res = x - y;
            co = x >= y;
            r = sx - sy;
        end else begin
            u = longint'(x) + longint'(y) + longint'(c);
            res = u[N-1:0];
            co = u[N];
            r = sx + sy + int'(c);
        end
        ov = (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
        return {co, ov, res};
    endfunction

    task automatic chk(input string name, input logic [N+1:0] act, input logic [N+1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference: request accepted when idle, result settles K edges later, consumed on out_ready
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            busy = 1'b0;
            known = 1'b1;
            expv = '0;
        end else if (!busy) begin
            if (in_valid) begin
                busy = 1'b1;
                acc = cyc;
                pend = calc(a, b, op_sub, cin);
                known = 1'b0;
            end
        end else if (cyc - acc == K) begin
            expv = pend;
            known = 1'b1;
        end else if (cyc - acc > K && out_ready) begin
            busy = 1'b0;
        end
    end

    // every-cycle comparison of DUT outputs against the reference
    always @(negedge clk) begin
        chk("in_ready", N'(in_ready), N'(!busy));
        chk("out_valid", N'(out_valid), N'(busy && (cyc - acc >= K)));
        if (known) chk("result", {cout, ovf, sum}, expv);
    end

    task automatic wait_result(input logic [N+1:0] lit, input bit consume);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", N'(n), N'(5));
        chk("dut_lit", {cout, ovf, sum}, lit);
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                         input logic c, input logic [N+1:0] lit, input bit consume);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", N'(in_ready), N'(1));
        chk("model_pin", calc(x, y, s, c), lit);
        a = x;
        b = y;
        op_sub = s;
        cin = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        op_sub = 1'($urandom);
        cin = 1'($urandom);
        wait_result(lit, consume);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", N'(in_ready), N'(1));
        chk("rst_valid", N'(out_valid), N'(0));
        chk("rst_out", {cout, ovf, sum}, '0);
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, {2'b00, 16'h2233}, 1'b1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h0000}, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h8000}, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE}, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, {2'b11, 16'h7FFF}, 1'b1);
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, {2'b00, 16'h2233}, 1'b0);
        a = 16'h1111;
        b = 16'h2222;
        op_sub = 1'b0;
        cin = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", N'(in_ready), N'(0));
            chk("bp_hold", {cout, ovf, sum}, {2'b00, 16'h2233});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", N'(in_ready), N'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_taken", N'(in_ready), N'(0));
        wait_result({2'b00, 16'h3333}, 1'b1);
        a = 16'h00FF;
        b = 16'h0F01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", N'(in_ready), N'(1));
        chk("mid_rst_valid", N'(out_valid), N'(0));
        chk("mid_rst_sum", N'(sum), '0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, {2'b00, 16'h0002}, 1'b1);
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            op_sub = 1'($urandom);
            cin = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 99) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs wide add/subtract by time-multiplexing one W-bit carry-look-ahead adder over K words, least-significant word first. The carry is registered between words. The block sits between a requester using a valid/ready handshake and the shared CLA datapath. It turns a combinational W-bit adder into a W*K-bit arithmetic unit with fixed latency and backpressure.

## Interface
- W, 4, word width of the internal CLA instance (bits per step)
- K, 4, number of words per operand; operand width is W*K
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- op_sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored)
- cin  in  1  carry-in for add
- a  in  W*K  operand A
- b  in  W*K  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  W*K  result
- cout  out  1  carry out of the top word; for subtract, 1 means no borrow (A >= B unsigned)
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, register a and b; for subtract, register ~b instead of b.
  - Set the carry register to cin for add, or to 1 for subtract.
  - Set word index idx = 0, then go to RUN.
- RUN (one word per cycle):
  - The CLA adds a[idx], b[idx] and the carry register.
  - Write the CLA sum into sum word idx.
  - The carry register takes the CLA carry-out.
  - idx increments.
  - When idx == K-1 on the current cycle, latch cout and ovf from the top word (MSB bit of word K-1), then go to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout and ovf are held stable until out_valid && out_ready, then go to IDLE.
- in_ready = (state == IDLE). out_valid = (state == DONE). No request overlap: a new request is accepted only after the result is consumed.
- in_valid is ignored outside IDLE. Operands, op_sub and cin are sampled only on the accept edge; later input changes have no effect.
- Width rules:
  - All arithmetic is modulo 2^(W*K).
  - idx is ceil(log2(K)) bits wide, minimum 1.
  - K = 1 is legal: RUN lasts one cycle.
- Reset values:
  - state = IDLE, so in_ready = 1 and out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - Carry register = 0, idx = 0.
- Reset during RUN or DONE: the operation is discarded, all outputs return to their reset values next cycle, and no result is presented.

## Timing
- Accept edge T: in_valid && in_ready sampled high.
- RUN occupies cycles T+1 .. T+K (K edges).
- out_valid is high from cycle T+K+1 onward. Latency from accept to result is K+1 cycles.
- If out_ready is high in the first DONE cycle, out_valid drops and in_ready rises on the next cycle. Best-case throughput is one operation per K+2 cycles.
- The carry chain crosses only one W-bit CLA per cycle. There is no combinational path from inputs to outputs; in_ready and out_valid are pure state decodes.
- out_ready being high while out_valid is low has no effect.

## Test plan
Settings for all cases: W=4, K=4.
- Add carry across words: a=0x1234, b=0x0FFF, cin=0, op_sub=0 → sum=0x2233, cout=0, ovf=0. out_valid rises exactly 5 cycles after the accept edge.
- Full wrap: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, op_sub=1, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0. Second case: a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - sum, cout and ovf stay stable; in_ready=0; the new request is not taken.
  - Raise out_ready: in_ready=1 next cycle and the pending request is accepted.
- Operand change after accept: alter a and b during RUN → result still reflects the values sampled on the accept edge.
- Reset mid-RUN: assert rst at RUN cycle 2.
  - Next cycle: in_ready=1, out_valid=0, sum=0.
  - A subsequent 0x0001+0x0001 returns 0x0002 with no stale carry.
